// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the sequential chunked adder.
//   state_t   : controller states IDLE / RUN / DONE
//   DEF_WIDTH : default operand/result width
//   DEF_CHUNK : default number of bits added per cycle
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Operand/result bundle for seq_chunk_adder.
// Optional feature macro: SEQ_CHUNK_ADDER_SUB_EN adds the 'sub' signal.
//   master : requester side (drives in_valid, a, b, cin[, sub])
//   slave  : adder side (drives in_ready, sum, cout, ovf, out_valid)
interface seq_chunk_adder_if
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             out_valid;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
  modport master (output in_valid, a, b, cin, sub,
                  input  in_ready, sum, cout, ovf, out_valid);
  modport slave  (input  in_valid, a, b, cin, sub,
                  output in_ready, sum, cout, ovf, out_valid);
`else
  modport master (output in_valid, a, b, cin,
                  input  in_ready, sum, cout, ovf, out_valid);
  modport slave  (input  in_valid, a, b, cin,
                  output in_ready, sum, cout, ovf, out_valid);
`endif

endinterface

// File: rtl/seq_chunk_adder_chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple-carry adder built from
// full-adder cells.
//   a, b : CHUNK-bit addends
//   cin  : carry into bit 0
//   sum  : CHUNK-bit sum
//   cout : carry out of the top bit
module chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: adds two WIDTH-bit operands CHUNK bits per cycle using a
// single chunk_adder and a carry register. One operation takes N+2 cycles
// (N = WIDTH/CHUNK); WIDTH must be an integer multiple of CHUNK.
// Optional feature macro: SEQ_CHUNK_ADDER_SUB_EN (adds subtract via bus.sub).
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : seq_chunk_adder_if slave -- in_valid/in_ready handshake, a, b, cin,
//         [sub], registered sum/cout/ovf and one-cycle out_valid pulse
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic            clk,
  input  logic            rst,
  seq_chunk_adder_if.slave bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t state_q;
  state_t state_d;

  logic        [IDX_W-1:0] idx;
  logic signed [WIDTH-1:0] a_reg;
  logic signed [WIDTH-1:0] b_reg;
  logic signed [WIDTH-1:0] acc;
  logic                    carry;

  logic        [WIDTH-1:0] b_eff;
  logic                    cin_eff;

  logic        [CHUNK-1:0] chunk_a;
  logic        [CHUNK-1:0] chunk_b;
  logic        [CHUNK-1:0] chunk_sum;
  logic                    chunk_cout;

  logic        [WIDTH-1:0] sum_reg;
  logic                    cout_reg;
  logic                    ovf_reg;
  logic                    out_valid_reg;

  // Effective B operand and carry-in as seen at acceptance.
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub ? 1'b1   : bus.cin;
`else
  assign b_eff   = bus.b;
  assign cin_eff = bus.cin;
`endif

  assign chunk_a = a_reg[idx*CHUNK +: CHUNK];
  assign chunk_b = b_reg[idx*CHUNK +: CHUNK];

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // Signed overflow: like-signed operands producing a result of the other sign.
  function automatic logic calc_ovf(input logic signed [WIDTH-1:0] op_a,
                                    input logic signed [WIDTH-1:0] op_b,
                                    input logic signed [WIDTH-1:0] res);
    return (op_a[WIDTH-1] == op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (idx == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture in IDLE, one chunk per RUN cycle, publish in DONE.
  // The carry out of the last chunk stays in 'carry' and becomes cout; it is
  // never fed back into chunk 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      acc           <= '0;
      carry         <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.a;
            b_reg <= b_eff;
            carry <= cin_eff;
            acc   <= '0;
            idx   <= '0;
          end
        end
        RUN: begin
          acc[idx*CHUNK +: CHUNK] <= chunk_sum;
          carry                   <= chunk_cout;
          idx                     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
        DONE: begin
          sum_reg       <= acc;
          cout_reg      <= carry;
          ovf_reg       <= calc_ovf(a_reg, b_reg, acc);
          out_valid_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed testbench for seq_chunk_adder: a 32/8 instance and an 8/8 instance
// on a shared clock and reset, with hand-computed expected results.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(32)) bus  ();
  seq_chunk_adder_if #(.WIDTH(8))  bus8 ();

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Waits up to 20 edges for out_valid on the 32-bit instance; lat is the
  // number of edges after acceptance (0 on timeout), stable is cleared if
  // sum moved before out_valid.
  task automatic wait_valid(input logic [31:0] hold, output int lat, output bit stable);
    lat    = 0;
    stable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
      if (bus.sum !== hold) stable = 1'b0;
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic c, input logic [31:0] es, input logic ec, input logic eo);
    logic [31:0] hold;
    int          lat;
    bit          stable;
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = c;
    #1;
    chk({tag, "_rdy_idle"}, bus.in_ready, 1'b1);
    hold = bus.sum;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = ~av;
    bus.b        = ~bv;
    bus.cin      = ~c;
    chk({tag, "_rdy_busy"}, bus.in_ready, 1'b0);
    wait_valid(hold, lat, stable);
    chk({tag, "_lat"}, lat, 5);
    chk({tag, "_stable"}, stable, 1'b1);
    chk({tag, "_sum"}, bus.sum, es);
    chk({tag, "_cout"}, bus.cout, ec);
    chk({tag, "_ovf"}, bus.ovf, eo);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, bus.out_valid, 1'b0);
    chk({tag, "_sum_hold"}, bus.sum, es);
    @(negedge clk);
  endtask

  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    bus8.in_valid = 1'b1;
    bus8.a        = av;
    bus8.b        = bv;
    bus8.cin      = 1'b0;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (bus8.out_valid) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_sum"}, bus8.sum, es);
    chk({tag, "_cout"}, bus8.cout, ec);
    chk({tag, "_ovf"}, bus8.ovf, eo);
    @(negedge clk);
  endtask

  initial begin
    int          lat;
    bit          stable;
    bit          seen;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus8.in_valid = 1'b0;
    bus8.a        = '0;
    bus8.b        = '0;
    bus8.cin      = 1'b0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    bus.sub       = 1'b0;
    bus8.sub      = 1'b0;
`endif

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_sum", bus.sum, 32'h0);
    chk("rst_cout", bus.cout, 1'b0);
    chk("rst_ovf", bus.ovf, 1'b0);

    // Release reset and present operands for the very next edge
    @(negedge clk);
    rst = 1'b0;
    run_op("wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("posovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("mixed",  32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0);
    run_op("cinrip", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    run_op("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    run_op("chunkc", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

`ifdef SEQ_CHUNK_ADDER_SUB_EN
    bus.sub = 1'b1;
    run_op("sub57", 32'h5, 32'h7, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub75", 32'h7, 32'h5, 1'b0, 32'h0000_0002, 1'b1, 1'b0);
    bus.sub = 1'b0;
`endif

    // Operands held during RUN are ignored, then taken in the next IDLE
    bus.in_valid = 1'b1;
    bus.a        = 32'h10;
    bus.b        = 32'h20;
    bus.cin      = 1'b0;
    @(posedge clk); #1;
    bus.a   = 32'h1000;
    bus.b   = 32'h2000;
    bus.cin = 1'b1;
    chk("hold_rdy_busy", bus.in_ready, 1'b0);
    wait_valid(32'h0000_0100, lat, stable);
    chk("hold_lat1", lat, 5);
    chk("hold_sum1", bus.sum, 32'h30);
    chk("hold_rdy_idle", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("hold_rdy_taken", bus.in_ready, 1'b0);
    chk("hold_sum1_kept", bus.sum, 32'h30);
    wait_valid(32'h30, lat, stable);
    chk("hold_lat2", lat, 5);
    chk("hold_stable2", stable, 1'b1);
    chk("hold_sum2", bus.sum, 32'h3001);
    @(negedge clk);

    // Leave all outputs nonzero, then abort an operation with reset
    run_op("preabort", 32'h8000_0000, 32'hC000_0000, 1'b0, 32'h4000_0000, 1'b1, 1'b1);
    bus.in_valid = 1'b1;
    bus.a        = 32'h1;
    bus.b        = 32'h1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_sum", bus.sum, 32'h0);
    chk("abort_cout", bus.cout, 1'b0);
    chk("abort_ovf", bus.ovf, 1'b0);
    chk("abort_rdy", bus.in_ready, 1'b1);
    chk("abort_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort_no_pulse", seen, 1'b0);
    @(negedge clk);

    // Single-chunk instance
    run8("n1_ovf", 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
    run8("n1_pos", 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

    // Normal operation after the abort
    run_op("recover", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits.
REQ-002 Parameter CHUNK, default 8: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 clk  input  1  sole clock, all state rising-edge.
REQ-004 rst  input  1  reset; one clock, asynchronous, active-high.
REQ-005 in_valid  input  1  operands valid.
REQ-006 in_ready  output  1  block idle, will accept operands this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in.
REQ-010 sub  input  1  subtract select (present only with SUB_EN).
REQ-011 sum  output  WIDTH  result.
REQ-012 cout  output  1  carry-out of MSB.
REQ-013 ovf  output  1  two's-complement signed overflow.
REQ-014 out_valid  output  1  one-cycle pulse, result valid.

Function
REQ-015 FSM SHALL have states IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 IDLE: in_valid=1 -> capture a, effective b, effective cin; clear chunk index and internal accumulator; go RUN.
REQ-017 RUN: each cycle add chunk[idx] of A and effective B plus carry register; write CHUNK-bit result into accumulator chunk idx; update carry register; idx==N-1 -> DONE, else idx+1.
REQ-018 DONE: load sum, cout, ovf registers from accumulator/final carry; assert out_valid for exactly this cycle; go IDLE.
REQ-019 Latency: operands accepted at edge T SHALL produce out_valid high in the cycle after edge T+N+1; throughput one operation per N+2 cycles.
REQ-020 sum, cout, ovf SHALL hold their values from DONE until the next DONE; they SHALL not change during RUN.
REQ-021 ovf = (A[MSB]==Beff[MSB]) and (sum[MSB]!=A[MSB]).
REQ-022 in_valid and operand changes while not in IDLE SHALL be ignored; no queuing.
REQ-023 N=1 (CHUNK=WIDTH) SHALL be legal: RUN lasts one cycle.
REQ-024 Carry chain wrap: carry out of chunk N-1 SHALL become cout, not re-enter chunk 0.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, idx 0, carry register 0, accumulator 0, sum 0, cout 0, ovf 0, out_valid 0, in_ready 1.
REQ-026 rst during RUN or DONE SHALL abort the operation; no out_valid SHALL be issued for it.
REQ-027 First acceptance possible on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro SEQ_CHUNK_ADDER_SUB_EN defined: port sub present; sub=1 at acceptance -> Beff = ~b, effective cin = 1 (A-B, cin ignored); cout=1 means no borrow.
REQ-029 Macro undefined: port sub absent; Beff = b, effective cin = cin; no subtract logic.

Structure
REQ-030 Shared package SHALL hold FSM state encoding (IDLE/RUN/DONE) and default WIDTH/CHUNK constants.
REQ-031 One sub-module chunk_adder (combinational CHUNK-bit ripple of full-adder cells: A, B, Cin -> Sum, Cout) SHALL be instantiated once per block.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-032 a=0xFFFFFFFF, b=1, cin=0 -> sum 0x00000000, cout 1, ovf 0; out_valid cycle after edge T+5.
REQ-033 a=0x7FFFFFFF, b=1, cin=0 -> sum 0x80000000, cout 0, ovf 1.
REQ-034 SUB_EN, a=5, b=7, sub=1 -> sum 0xFFFFFFFE, cout 0, ovf 0; a=7, b=5 -> sum 2, cout 1.
REQ-035 second in_valid with new operands held during RUN -> ignored, in_ready 0, first result unchanged; second accepted only in next IDLE.
REQ-036 rst pulsed mid-RUN -> all outputs 0 asynchronously, in_ready 1, no out_valid pulse.
REQ-037 WIDTH=CHUNK=8, a=0x80, b=0x80 -> sum 0x00, cout 1, ovf 1, out_valid cycle after edge T+2.
